sdram_responder: RTL and testbench

- Synthesizable SDRAM device emulator: the target end of the 16-bit SDR SDRAM command bus our controllers drive.
- Decodes CS/RAS/CAS/WE commands, tracks per-bank open rows and the mode register, and services burst reads/writes from on-chip block RAM.
- Flags protocol violations.
- Used in simulation and on-FPGA loopback so controller timing can be verified without an external chip.

---
 rtl/sdram_responder.sv | 233 +++++++++++++++++++++++
 tb/tb_sdram_responder.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/sdram_responder.sv
// SDR SDRAM target emulator: decodes the 16-bit SDRAM command bus, keeps
// per-bank row state and the mode register, serves bursts from block RAM,
// and raises a sticky flag on protocol violations.
module sdram_responder #(
  parameter int ROW_BITS = 2,
  parameter int COL_BITS = 8
) (
  input  logic        clk_96,
  input  logic        reset,
  input  logic        sd_cs,
  input  logic        sd_ras,
  input  logic        sd_cas,
  input  logic        sd_we,
  input  logic [1:0]  sd_ba,
  input  logic [12:0] sd_addr,
  input  logic [1:0]  sd_dqm,
  input  logic [15:0] sd_data_in,
  input  logic        sd_data_wr,
  output logic [15:0] sd_data_out,
  output logic        sd_data_oe,
  output logic        mode_set,
  output logic        proto_err,
  output logic [15:0] refresh_cnt
);

  localparam int AW    = 2 + ROW_BITS + COL_BITS;
  localparam int DEPTH = 1 << AW;

  logic [7:0] r_mem_hi [0:DEPTH-1];
  logic [7:0] r_mem_lo [0:DEPTH-1];

  // mode register
  logic [1:0] r_bl_log;
  logic       r_interleave;
  logic       r_cl3;
  logic       r_single_wr;

  // bank state
  logic [3:0]          r_bank_open;
  logic [ROW_BITS-1:0] r_row [4];

  // burst generator
  logic                r_burst_active;
  logic                r_burst_write;
  logic                r_burst_ap;
  logic [1:0]          r_burst_bank;
  logic [ROW_BITS-1:0] r_burst_row;
  logic [COL_BITS-1:0] r_burst_base;
  logic [2:0]          r_beat;
  logic                r_ap_pend;
  logic [1:0]          r_ap_bank;

  // read pipeline and read-DQM delay
  logic          r_p0_v, r_p1_v;
  logic [AW-1:0] r_p0_a, r_p1_a;
  logic [1:0]    r_dqm_d;

  logic [3:0]          w_cmd;
  logic                w_act, w_rd, w_wr, w_bt, w_pre, w_ref, w_lmr, w_rw;
  logic                w_rw_ok, w_stop, w_gen, w_gen_last, w_new_burst;
  logic [2:0]          w_bl_m1;
  logic [COL_BITS-1:0] w_col_base, w_gen_col;
  logic [AW-1:0]       w_beat_addr, w_out_a;
  logic                w_wr_en, w_rd_push, w_out_v;
  logic                w_unused;

  // Column of beat i: sequential wraps inside the BL-aligned block, interleaved XORs.
  function automatic logic [COL_BITS-1:0] f_burst_col(
    input logic [COL_BITS-1:0] i_base,
    input logic [2:0]          i_beat,
    input logic [1:0]          i_bl_log,
    input logic                i_il
  );
    logic [COL_BITS-1:0] v_one, v_mask, v_beat;
    v_one  = COL_BITS'(1);
    v_beat = COL_BITS'(i_beat);
    v_mask = (v_one << i_bl_log) - v_one;
    if (i_il) return i_base ^ v_beat;
    return (i_base & ~v_mask) | ((i_base + v_beat) & v_mask);
  endfunction

  assign w_cmd = {sd_cs, sd_ras, sd_cas, sd_we};
  assign w_act = (w_cmd == 4'b0011);
  assign w_rd  = (w_cmd == 4'b0101);
  assign w_wr  = (w_cmd == 4'b0100);
  assign w_bt  = (w_cmd == 4'b0110);
  assign w_pre = (w_cmd == 4'b0010);
  assign w_ref = (w_cmd == 4'b0001);
  assign w_lmr = (w_cmd == 4'b0000);
  assign w_rw  = w_rd | w_wr;

  assign w_bl_m1     = 3'((4'd1 << r_bl_log) - 4'd1);
  assign w_rw_ok     = w_rw & r_bank_open[sd_ba];
  assign w_stop      = r_burst_active &
                       (w_rw | w_bt | (w_pre & (sd_addr[10] | (sd_ba == r_burst_bank))));
  assign w_gen       = r_burst_active & ~w_stop;
  assign w_gen_last  = w_gen & (r_beat == w_bl_m1);
  assign w_new_burst = w_rw_ok & (r_bl_log != 2'd0) & ~(w_wr & r_single_wr);

  assign w_col_base  = sd_addr[COL_BITS-1:0];
  assign w_gen_col   = f_burst_col(r_burst_base, r_beat, r_bl_log, r_interleave);
  assign w_beat_addr = w_rw ? {sd_ba, r_row[sd_ba], w_col_base}
                            : {r_burst_bank, r_burst_row, w_gen_col};
  assign w_wr_en     = (w_wr & w_rw_ok) | (w_gen & r_burst_write);
  assign w_rd_push   = (w_rd & w_rw_ok) | (w_gen & ~r_burst_write);

  // CL2 reads come from the first pipe stage, CL3 from the second
  assign w_out_v = r_cl3 ? r_p1_v : r_p0_v;
  assign w_out_a = r_cl3 ? r_p1_a : r_p0_a;

  // upper row bits alias by design
  assign w_unused = ^sd_addr;

  // Byte-masked write port; memory is never cleared by reset.
  always_ff @(posedge clk_96) begin
    if (w_wr_en && !sd_dqm[1]) r_mem_hi[w_beat_addr] <= sd_data_in[15:8];
    if (w_wr_en && !sd_dqm[0]) r_mem_lo[w_beat_addr] <= sd_data_in[7:0];
  end

  // Registered read data; DQM sampled one edge earlier blanks bytes (latency 2 at the pins).
  always_ff @(posedge clk_96) begin
    if (reset) begin
      sd_data_out <= 16'h0000;
      sd_data_oe  <= 1'b0;
    end else begin
      sd_data_oe  <= w_out_v;
      sd_data_out <= w_out_v ? {(r_dqm_d[1] ? 8'h00 : r_mem_hi[w_out_a]),
                                (r_dqm_d[0] ? 8'h00 : r_mem_lo[w_out_a])} : 16'h0000;
    end
  end

  // Read address pipeline; beats already issued keep draining after a stop.
  always_ff @(posedge clk_96) begin
    if (reset) begin
      r_p0_v <= 1'b0;
      r_p1_v <= 1'b0;
      r_p0_a <= '0;
      r_p1_a <= '0;
    end else begin
      r_p0_v <= w_rd_push;
      r_p0_a <= w_beat_addr;
      r_p1_v <= r_p0_v;
      r_p1_a <= r_p0_a;
    end
  end

  // Command decode, bank/mode tracking, burst generator and violation flag.
  always_ff @(posedge clk_96) begin
    if (reset) begin
      mode_set       <= 1'b0;
      proto_err      <= 1'b0;
      refresh_cnt    <= 16'h0000;
      r_bl_log       <= 2'd0;
      r_interleave   <= 1'b0;
      r_cl3          <= 1'b0;
      r_single_wr    <= 1'b0;
      r_bank_open    <= 4'b0000;
      for (int b = 0; b < 4; b++) r_row[b] <= '0;
      r_burst_active <= 1'b0;
      r_burst_write  <= 1'b0;
      r_burst_ap     <= 1'b0;
      r_burst_bank   <= 2'd0;
      r_burst_row    <= '0;
      r_burst_base   <= '0;
      r_beat         <= 3'd0;
      r_ap_pend      <= 1'b0;
      r_ap_bank      <= 2'd0;
      r_dqm_d        <= 2'b00;
    end else begin
      r_dqm_d   <= sd_dqm;
      r_ap_pend <= 1'b0;
      if (r_ap_pend) r_bank_open[r_ap_bank] <= 1'b0;

      if (w_gen) begin
        r_beat <= r_beat + 3'd1;
        if (w_gen_last) begin
          r_burst_active <= 1'b0;
          if (r_burst_ap) begin
            r_ap_pend <= 1'b1;
            r_ap_bank <= r_burst_bank;
          end
        end
      end
      if (w_stop) begin
        r_burst_active <= 1'b0;
        if (r_burst_ap) r_bank_open[r_burst_bank] <= 1'b0;
      end

      if (w_new_burst) begin
        r_burst_active <= 1'b1;
        r_burst_write  <= w_wr;
        r_burst_ap     <= sd_addr[10];
        r_burst_bank   <= sd_ba;
        r_burst_row    <= r_row[sd_ba];
        r_burst_base   <= w_col_base;
        r_beat         <= 3'd1;
      end else if (w_rw_ok && sd_addr[10]) begin
        r_ap_pend <= 1'b1;
        r_ap_bank <= sd_ba;
      end

      if (w_act) begin
        if (r_bank_open[sd_ba]) proto_err <= 1'b1;
        r_bank_open[sd_ba] <= 1'b1;
        r_row[sd_ba]       <= sd_addr[ROW_BITS-1:0];
      end
      if (w_pre) begin
        if (sd_addr[10]) r_bank_open <= 4'b0000;
        else             r_bank_open[sd_ba] <= 1'b0;
      end
      if (w_rw && (!r_bank_open[sd_ba] || !mode_set)) proto_err <= 1'b1;
      if (w_ref) begin
        if (|r_bank_open) proto_err <= 1'b1;
        if (refresh_cnt != 16'hFFFF) refresh_cnt <= refresh_cnt + 16'd1;
      end
      if (w_lmr) begin
        case (sd_addr[2:0])
          3'b001:  r_bl_log <= 2'd1;
          3'b010:  r_bl_log <= 2'd2;
          3'b011:  r_bl_log <= 2'd3;
          default: r_bl_log <= 2'd0;
        endcase
        r_interleave <= sd_addr[3];
        r_cl3        <= (sd_addr[6:4] == 3'd3);
        r_single_wr  <= sd_addr[9];
        mode_set     <= 1'b1;
        if ((|r_bank_open) || r_burst_active) proto_err <= 1'b1;
      end
      if (sd_data_wr && sd_data_oe) proto_err <= 1'b1;
    end
  end

endmodule

// File: tb/tb_sdram_responder.sv
// Directed bench for sdram_responder: burst ordering, CAS latency, read DQM,
// termination, auto-precharge, refresh, contention and reset behaviour.
module tb_sdram_responder;

  localparam logic [3:0] C_NOP = 4'b0111;
  localparam logic [3:0] C_ACT = 4'b0011;
  localparam logic [3:0] C_RD  = 4'b0101;
  localparam logic [3:0] C_WR  = 4'b0100;
  localparam logic [3:0] C_BT  = 4'b0110;
  localparam logic [3:0] C_PRE = 4'b0010;
  localparam logic [3:0] C_REF = 4'b0001;
  localparam logic [3:0] C_LMR = 4'b0000;

  logic        clk_96;
  logic        reset;
  logic        sd_cs, sd_ras, sd_cas, sd_we;
  logic [1:0]  sd_ba;
  logic [12:0] sd_addr;
  logic [1:0]  sd_dqm;
  logic [15:0] sd_data_in;
  logic        sd_data_wr;
  logic [15:0] sd_data_out;
  logic        sd_data_oe;
  logic        mode_set;
  logic        proto_err;
  logic [15:0] refresh_cnt;

  int          n_checks = 0;
  int          n_errors = 0;
  logic [15:0] cap [8];

  sdram_responder #(.ROW_BITS(2), .COL_BITS(8)) dut (
    .clk_96     (clk_96),
    .reset      (reset),
    .sd_cs      (sd_cs),
    .sd_ras     (sd_ras),
    .sd_cas     (sd_cas),
    .sd_we      (sd_we),
    .sd_ba      (sd_ba),
    .sd_addr    (sd_addr),
    .sd_dqm     (sd_dqm),
    .sd_data_in (sd_data_in),
    .sd_data_wr (sd_data_wr),
    .sd_data_out(sd_data_out),
    .sd_data_oe (sd_data_oe),
    .mode_set   (mode_set),
    .proto_err  (proto_err),
    .refresh_cnt(refresh_cnt)
  );

  initial clk_96 = 1'b0;
  always #5 clk_96 = ~clk_96;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a,
                       input logic [1:0] dqm, input logic [15:0] din, input logic wr);
    {sd_cs, sd_ras, sd_cas, sd_we} = c;
    sd_ba      = ba;
    sd_addr    = a;
    sd_dqm     = dqm;
    sd_data_in = din;
    sd_data_wr = wr;
  endtask

  task automatic tick;
    @(posedge clk_96);
    #1;
  endtask

  task automatic nop;
    drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
    tick();
  endtask

  task automatic cmd(input logic [3:0] c, input logic [1:0] ba, input logic [12:0] a);
    drive(c, ba, a, 2'b00, 16'h0, 1'b0);
    tick();
    drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
  endtask

  task automatic do_reset;
    reset = 1'b1;
    drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
    tick();
    tick();
    reset = 1'b0;
  endtask

  // beat i carries d0+i
  task automatic write_burst(input logic [1:0] ba, input logic [12:0] a,
                             input logic [15:0] d0, input int nb);
    drive(C_WR, ba, a, 2'b00, d0, 1'b1);
    tick();
    for (int i = 1; i < nb; i++) begin
      drive(C_NOP, 2'd0, 13'h0, 2'b00, d0 + 16'(i), 1'b1);
      tick();
    end
    drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
  endtask

  // Issues a READ at edge k, then watches edges k+1..k+12; the first edge
  // offset at which oe is seen high is CL-1 (data captured by the host at k+CL).
  task automatic run_read(input string tag, input logic [1:0] ba, input logic [12:0] a,
                          input logic [1:0] dqm1, input int term_at, input int exp_n,
                          input int exp_first, input logic [63:0] exp_v);
    int n;
    int first;
    n = 0;
    first = -1;
    for (int i = 0; i < 8; i++) cap[i] = 16'hxxxx;
    drive(C_RD, ba, a, 2'b00, 16'h0, 1'b0);
    tick();
    for (int t = 1; t <= 12; t++) begin
      drive((t == term_at) ? C_BT : C_NOP, 2'd0, 13'h0, (t == 1) ? dqm1 : 2'b00, 16'h0, 1'b0);
      tick();
      if (sd_data_oe === 1'b1) begin
        if (first < 0) first = t;
        if (n < 8) cap[n] = sd_data_out;
        n++;
      end
    end
    check({tag, "_beats"}, 32'(n), 32'(exp_n));
    if (exp_n > 0) check({tag, "_latency"}, 32'(first), 32'(exp_first));
    for (int i = 0; i < exp_n && i < 4; i++)
      check($sformatf("%s_beat%0d", tag, i), {16'h0, cap[i]}, {16'h0, exp_v[63-16*i -: 16]});
  endtask

  initial begin
    int oe_seen;
    reset = 1'b1;
    drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
    repeat (3) tick();
    reset = 1'b0;
    tick();
    check("rst_oe",      32'(sd_data_oe),  32'd0);
    check("rst_out",     32'(sd_data_out), 32'd0);
    check("rst_mode_set", 32'(mode_set),   32'd0);
    check("rst_err",     32'(proto_err),   32'd0);
    check("rst_refresh", 32'(refresh_cnt), 32'd0);

    // BL4 sequential CL2
    cmd(C_LMR, 2'd0, 13'h022);
    check("lmr_mode_set", 32'(mode_set), 32'd1);
    cmd(C_ACT, 2'd1, 13'h005);
    write_burst(2'd1, 13'h010, 16'hA5A5, 4);
    nop();
    nop();
    run_read("rd_seq10", 2'd1, 13'h010, 2'b00, 0, 4, 1, 64'hA5A5_A5A6_A5A7_A5A8);
    run_read("rd_seq12", 2'd1, 13'h012, 2'b00, 0, 4, 1, 64'hA5A7_A5A8_A5A5_A5A6);
    run_read("rd_seq11", 2'd1, 13'h011, 2'b00, 0, 4, 1, 64'hA5A6_A5A7_A5A8_A5A5);
    check("err_after_seq", 32'(proto_err), 32'd0);

    // BL4 interleaved CL2
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h02A);
    cmd(C_ACT, 2'd1, 13'h005);
    run_read("rd_il12", 2'd1, 13'h012, 2'b00, 0, 4, 1, 64'hA5A7_A5A8_A5A5_A5A6);
    run_read("rd_il11", 2'd1, 13'h011, 2'b00, 0, 4, 1, 64'hA5A6_A5A5_A5A8_A5A7);

    // BL4 sequential CL3, low byte masked at k+1
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h032);
    cmd(C_ACT, 2'd1, 13'h005);
    run_read("rd_cl3_dqm", 2'd1, 13'h010, 2'b01, 0, 4, 2, 64'hA500_A5A6_A5A7_A5A8);
    check("err_after_mode_changes", 32'(proto_err), 32'd0);

    // BL8 CL2 with burst terminate at k+2
    cmd(C_PRE, 2'd0, 13'h400);
    cmd(C_LMR, 2'd0, 13'h023);
    cmd(C_ACT, 2'd1, 13'h005);
    run_read("rd_bl8_term",  2'd1, 13'h010, 2'b00, 2, 2, 1, 64'hA5A5_A5A6_0000_0000);
    run_read("rd_bl8_term2", 2'd1, 13'h012, 2'b00, 2, 2, 1, 64'hA5A7_A5A8_0000_0000);
    check("err_bank_still_open", 32'(proto_err), 32'd0);

    // write with auto-precharge closes bank 0; the following READ is illegal
    cmd(C_ACT, 2'd0, 13'h000);
    write_burst(2'd0, 13'h440, 16'h1111, 8);
    repeat (3) nop();
    check("err_after_ap_write", 32'(proto_err), 32'd0);
    run_read("rd_after_ap", 2'd0, 13'h040, 2'b00, 0, 0, 0, 64'h0);
    check("err_read_closed_bank", 32'(proto_err), 32'd1);

    // READ before any LOAD_MODE: flagged, served with reset mode (BL1), memory kept
    do_reset();
    nop();
    check("rst2_err",      32'(proto_err), 32'd0);
    check("rst2_mode_set", 32'(mode_set),  32'd0);
    cmd(C_ACT, 2'd1, 13'h005);
    check("err_act_premode", 32'(proto_err), 32'd0);
    run_read("rd_premode", 2'd1, 13'h010, 2'b00, 0, 1, 1, 64'hA5A5_0000_0000_0000);
    check("err_rw_before_mode", 32'(proto_err), 32'd1);

    // AUTO_REFRESH with bank 2 open
    do_reset();
    cmd(C_LMR, 2'd0, 13'h022);
    cmd(C_ACT, 2'd2, 13'h000);
    cmd(C_REF, 2'd0, 13'h000);
    check("ref_open_cnt", 32'(refresh_cnt), 32'd1);
    check("ref_open_err", 32'(proto_err),   32'd1);

    // legal refresh, DQ contention, then reset in the middle of a read
    do_reset();
    cmd(C_LMR, 2'd0, 13'h022);
    cmd(C_REF, 2'd0, 13'h000);
    check("ref_idle_cnt", 32'(refresh_cnt), 32'd1);
    check("ref_idle_err", 32'(proto_err),   32'd0);
    cmd(C_ACT, 2'd1, 13'h005);
    cmd(C_RD, 2'd1, 13'h010);
    nop();
    check("mid_rd_oe",  32'(sd_data_oe),  32'd1);
    check("mid_rd_out", 32'(sd_data_out), 32'h0000A5A5);
    drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b1);
    tick();
    check("contention_err", 32'(proto_err), 32'd1);
    reset = 1'b1;
    drive(C_NOP, 2'd0, 13'h0, 2'b00, 16'h0, 1'b0);
    tick();
    check("rst_mid_oe",       32'(sd_data_oe),  32'd0);
    check("rst_mid_out",      32'(sd_data_out), 32'd0);
    check("rst_mid_mode_set", 32'(mode_set),    32'd0);
    check("rst_mid_err",      32'(proto_err),   32'd0);
    check("rst_mid_refresh",  32'(refresh_cnt), 32'd0);
    reset = 1'b0;
    oe_seen = 0;
    repeat (6) begin
      tick();
      if (sd_data_oe !== 1'b0) oe_seen++;
    end
    check("oe_after_reset", 32'(oe_seen), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
